// File: rtl/match_sequencer.sv
// match_sequencer: penalty shoot-out game flow (START -> turns -> WINNER/LOSER), round and score keeping.
// Rev 1.0
`default_nettype none

module match_sequencer #(
    parameter int ROUNDS        = 5,
    parameter int RESULT_CYCLES = 65_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       solo_enable,
    input  logic       left_clicked,
    input  logic       shot_done,
    input  logic       is_scored,
    output logic [2:0] screen_sel,
    output logic       player_role,
    output logic [3:0] round_idx,
    output logic [3:0] score_player,
    output logic [3:0] score_opp,
    output logic       solo_mode,
    output logic       game_over
);

    localparam int              HOLD_W    = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESULT_CYCLES - 1);
    localparam logic [3:0]      ROUNDS_4  = 4'(ROUNDS);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_SHOOT  = 3'd1,
        ST_KEEP   = 3'd2,
        ST_HOLD_S = 3'd3,
        ST_HOLD_K = 3'd4,
        ST_WIN    = 3'd5,
        ST_LOSE   = 3'd6
    } state_t;

    state_t            state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic              btn_prev;
    logic              click;
    logic [3:0]        round_n, round_inc, score_player_n, score_opp_n;
    logic              solo_n;
    logic [2:0]        screen_n;
    logic              role_n, over_n;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    always_comb begin
        state_n        = state;
        hold_cnt_n     = hold_cnt;
        round_n        = round_idx;
        score_player_n = score_player;
        score_opp_n    = score_opp;
        solo_n         = solo_mode;
        click          = left_clicked & ~btn_prev;
        round_inc      = sat_inc(round_idx);

        case (state)
            ST_START: begin
                if (click) begin
                    solo_n         = solo_enable;
                    round_n        = 4'd0;
                    score_player_n = 4'd0;
                    score_opp_n    = 4'd0;
                    state_n        = ST_SHOOT;
                end
            end
            ST_SHOOT: begin
                if (shot_done) begin
                    if (is_scored)      score_player_n = sat_inc(score_player);
                    else if (solo_mode) score_opp_n    = sat_inc(score_opp);
                    hold_cnt_n = HOLD_LOAD;
                    state_n    = ST_HOLD_S;
                end
            end
            ST_KEEP: begin
                if (shot_done) begin
                    if (is_scored) score_opp_n = sat_inc(score_opp);
                    hold_cnt_n = HOLD_LOAD;
                    state_n    = ST_HOLD_K;
                end
            end
            ST_HOLD_S, ST_HOLD_K: begin
                if (hold_cnt != '0) begin
                    hold_cnt_n = hold_cnt - HOLD_W'(1);
                end else if (state == ST_HOLD_S && !solo_mode) begin
                    state_n = ST_KEEP;
                end else begin
                    // End of round: a tie past regulation keeps going one round at a time
                    round_n = round_inc;
                    if (round_inc >= ROUNDS_4 && score_player != score_opp)
                        state_n = (score_player > score_opp) ? ST_WIN : ST_LOSE;
                    else
                        state_n = ST_SHOOT;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (click) state_n = ST_START;
            end
            default: state_n = ST_START;
        endcase
    end

    always_comb begin
        screen_n = 3'd0;
        role_n   = 1'b1;
        over_n   = 1'b0;
        case (state_n)
            ST_SHOOT, ST_HOLD_S: screen_n = 3'd1;
            ST_KEEP, ST_HOLD_K: begin
                screen_n = 3'd2;
                role_n   = 1'b0;
            end
            ST_WIN: begin
                screen_n = 3'd3;
                over_n   = 1'b1;
            end
            ST_LOSE: begin
                screen_n = 3'd4;
                over_n   = 1'b1;
            end
            default: screen_n = 3'd0;
        endcase
    end

    // Previous button value resets high so a button held through reset is not a click
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_START;
            hold_cnt     <= '0;
            btn_prev     <= 1'b1;
            round_idx    <= 4'd0;
            score_player <= 4'd0;
            score_opp    <= 4'd0;
            solo_mode    <= 1'b0;
            screen_sel   <= 3'd0;
            player_role  <= 1'b1;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_cnt_n;
            btn_prev     <= left_clicked;
            round_idx    <= round_n;
            score_player <= score_player_n;
            score_opp    <= score_opp_n;
            solo_mode    <= solo_n;
            screen_sel   <= screen_n;
            player_role  <= role_n;
            game_over    <= over_n;
        end
    end

endmodule

`default_nettype wire
